// File: rtl/riscorvo_dmem_responder.sv
// Target-side data-memory responder for the riscorvo core: word RAM with masked writes and programmable wait states.
// Define RISCORVO_DMEM_RAND_WAIT_EN to add 0..3 pseudo-random extra wait cycles per request.
module riscorvo_dmem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic        read_write_i,
  input  logic [3:0]  mask_i,
  output logic        ready_o,
  output logic [31:0] read_data_o,
  output logic        err_o
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] WINDOW    = 33'(MEM_WORDS) << 2;
  localparam logic [4:0]  WAIT_BASE = 5'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic [4:0]    cnt_reg, cnt_next;
  logic [AW-1:0] idx_reg;
  logic          inwin_reg;
  logic          rw_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    mask_reg;

  logic [31:0]   req_offset;
  logic          req_inwin;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] rd_idx;
  logic          accept;
  logic          rd_en;
  logic [4:0]    wait_val;
  logic [31:0]   ram_q;

  // Wrap-around subtraction makes addresses below BASE_ADDR land far outside the window.
  assign req_offset = addr_i - BASE_ADDR;
  assign req_inwin  = {1'b0, req_offset} < WINDOW;
  assign req_idx    = req_offset[AW+1:2];
  assign accept     = (state_reg == IDLE) && valid_i;

`ifdef RISCORVO_DMEM_RAND_WAIT_EN
  logic [7:0] lfsr_reg;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; the current value sets this request's wait, then it steps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_reg <= 8'hA5;
    end else if (accept) begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  assign wait_val = WAIT_BASE + {3'b000, lfsr_reg[1:0]};
`else
  assign wait_val = WAIT_BASE;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    ready_o     = 1'b0;
    read_data_o = 32'h0;
    err_o       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          cnt_next = wait_val;
          if (wait_val == 5'd0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 5'd1;
        if (cnt_reg <= 5'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        ready_o = 1'b1;
        err_o   = !inwin_reg;
        if (!rw_reg && inwin_reg) begin
          read_data_o = ram_q;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 5'd0;
      idx_reg   <= '0;
      inwin_reg <= 1'b0;
      rw_reg    <= 1'b0;
      wdata_reg <= 32'h0;
      mask_reg  <= 4'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        idx_reg   <= req_idx;
        inwin_reg <= req_inwin;
        rw_reg    <= read_write_i;
        wdata_reg <= write_data_i;
        mask_reg  <= mask_i;
      end
    end
  end

  // The RAM is read on the edge entering RESP; with zero wait that edge is the accept edge,
  // so the live request address is used while still in IDLE.
  assign rd_en  = (state_next == RESP);
  assign rd_idx = (state_reg == IDLE) ? req_idx : idx_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [MEM_WORDS];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if ((state_reg == RESP) && rw_reg && inwin_reg && mask_reg[gi]) begin
          mem[idx_reg] <= wdata_reg[gi*8 +: 8];
        end
        if (rd_en) begin
          q_reg <= mem[rd_idx];
        end
      end

      assign ram_q[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: doc/riscorvo_dmem_responder.md
Name: riscorvo_dmem_responder

Overview:
- Data-memory responder (target side) for the riscorvo core data interface (valid/ready, addr, write_data, read_write, mask, read_data).
- Backs the interface with a word-organised on-chip RAM and programmable wait states.
- Used in simulation benches and FPGA builds in place of an external memory.
- Signals an error for addresses outside its window.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_WORDS*4.
- WAIT_STATES, 1, extra cycles between acceptance and response; range 0..15.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- valid_i  input  1  request valid from core (valid_data_o)
- addr_i  input  32  byte address
- write_data_i  input  32  store data
- read_write_i  input  1  1 = write, 0 = read
- mask_i  input  4  byte enables; bit n selects byte lane n
- ready_o  output  1  one-cycle response strobe (to ready_data_i)
- read_data_o  output  32  load data, valid only while ready_o=1
- err_o  output  1  out-of-window access, valid only while ready_o=1

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state IDLE, ready_o=0, read_data_o=0, err_o=0, wait counter=0. RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
- Acceptance: in IDLE with valid_i=1, latch addr_i, write_data_i, read_write_i and mask_i. Load the counter with the wait value and go to WAIT; if the wait value is 0, go to RESP directly.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
- RESP:
  - ready_o=1 for exactly one cycle.
  - Write: perform the masked write this cycle. Read: drive read_data_o from RAM with all four lanes, mask ignored.
  - Return to IDLE next cycle.
- Latency: request accepted at cycle 0 gives ready_o at cycle WAIT_STATES+1.
  - Throughput: at most one transaction per WAIT_STATES+2 cycles.
  - valid_i still high in the cycle after RESP is treated as a new request.
- Latched request: the latched copy is authoritative. Changes on addr_i, write_data_i or mask_i after acceptance are ignored.
- valid_i dropped mid-transaction: the transaction still completes with a ready_o pulse. The bench flags this as a protocol violation.
- Address decode:
  - offset = addr_i - BASE_ADDR, 32-bit wrap-around subtraction.
  - In window when offset < MEM_WORDS*4.
  - Word index = offset[log2(MEM_WORDS)+1:2]; addr_i[1:0] is ignored, accesses are word-aligned.
- Out of window:
  - Writes are dropped.
  - read_data_o=0 in RESP.
  - err_o=1 together with ready_o, for both reads and writes.
- mask_i=0 write: completes with ready_o and modifies nothing.
- Outside RESP: read_data_o=0 and err_o=0.
- Reset asserted mid-transaction: return immediately to IDLE and drop ready_o. A pending write is not performed.

Optional Feature:
- Macro: RISCORVO_DMEM_RAND_WAIT_EN.
- With the macro defined:
  - An 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded to 8'hA5 at reset, advances once per accepted request.
  - Wait value = WAIT_STATES + lfsr[1:0], giving latency WAIT_STATES+1 to WAIT_STATES+4. This stresses the core's ready handling.
- Without the macro: no LFSR is instantiated and the wait value is WAIT_STATES, fixed.

Test Plan:
- Write, WAIT_STATES=1: addr 0x10, data 0xDEADBEEF, mask 4'hF -> ready_o 2 cycles after acceptance. A following read of 0x10 returns 0xDEADBEEF with err_o=0.
- Byte-masked write: 0x11223344 to 0x20, then 0xAABBCCDD with mask 4'b0101 -> read of 0x20 returns 0x11BB33DD.
- Out of window, MEM_WORDS=1024: write 0x0000_1000, then read it -> both complete with err_o=1 and read_data_o=0. Word 0 is unchanged.
- WAIT_STATES=0 back-to-back: valid_i held high for 6 cycles -> ready_o pulses every 2nd cycle, 3 pulses total, never two consecutive cycles.
- Reset during WAIT of a write to 0x30 holding 0x0 (WAIT_STATES=3) -> ready_o never asserts. After reset, a read of 0x30 returns 0x0.
- RISCORVO_DMEM_RAND_WAIT_EN defined, WAIT_STATES=1: 16 reads -> every latency is in 2..5 cycles, and the latency sequence matches the LFSR reference model seeded with 0xA5.
